// File: rtl/ram_rd_arbiter.sv
// ----------------------------------------------------------------------------
// ram_rd_arbiter
//   Shares one read port of the picture RAM between the display scanner
//   (port 0, latency-critical, default winner) and the CNN feature fetch
//   (port 1, throughput-tolerant). One grant per cycle. A starvation counter
//   forces a port-1 win after STARVE_MAX consecutive denials. Returned data
//   is steered to the winner READ_LAT cycles after its grant.
//
// Ports
//   clk, rst_n           : clock, synchronous active-low reset
//   hold                 : 1 = issue no grants (frame being written)
//   req0/addr0           : port 0 request (level, held until granted)/address
//   gnt0                 : port 0 accepted this cycle
//   rvalid0/rdata0       : port 0 return strobe/data (data holds when idle)
//   req1/addr1           : port 1 request/address
//   gnt1                 : port 1 accepted this cycle
//   rvalid1/rdata1       : port 1 return strobe/data
//   ram_rd/ram_addr      : RAM read strobe/address (addr0 when no grant)
//   ram_rdata            : RAM read data, valid READ_LAT cycles after ram_rd
// ----------------------------------------------------------------------------
module ram_rd_arbiter #(
   parameter int unsigned AW         = 10,
   parameter int unsigned DW         = 8,
   parameter int unsigned READ_LAT   = 1,
   parameter int unsigned STARVE_MAX = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          hold,
   input  logic          req0,
   input  logic [AW-1:0] addr0,
   output logic          gnt0,
   output logic          rvalid0,
   output logic [DW-1:0] rdata0,
   input  logic          req1,
   input  logic [AW-1:0] addr1,
   output logic          gnt1,
   output logic          rvalid1,
   output logic [DW-1:0] rdata1,
   output logic          ram_rd,
   output logic [AW-1:0] ram_addr,
   input  logic [DW-1:0] ram_rdata
);

   localparam int unsigned SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
   localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

   logic [SW-1:0]       r_scnt;
   logic [READ_LAT-1:0] r_tag_v;
   logic [READ_LAT-1:0] r_tag_p;
   logic [DW-1:0]       r_rdata0;
   logic [DW-1:0]       r_rdata1;

   logic                w_en;
   logic                w_force1;
   logic                w_gnt0;
   logic                w_gnt1;
   logic [READ_LAT:0]   w_tag_v_nxt;
   logic [READ_LAT:0]   w_tag_p_nxt;
   logic                w_rv0;
   logic                w_rv1;

   // ---------------- combinational grant mux ----------------
   assign w_en     = rst_n & ~hold;
   assign w_force1 = (STARVE_MAX != 0) && req1 && (r_scnt == SMAX);
   assign w_gnt1   = w_en & req1 & (~req0 | w_force1);
   assign w_gnt0   = w_en & req0 & ~w_force1;

   assign gnt0     = w_gnt0;
   assign gnt1     = w_gnt1;
   assign ram_rd   = w_gnt0 | w_gnt1;
   assign ram_addr = w_gnt1 ? addr1 : addr0;

   // ---------------- starvation counter ----------------
   // Saturates at all-ones so a disabled guard (STARVE_MAX=0) cannot wrap.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_scnt <= '0;
      end else if (!hold) begin
         if (!req1 || w_gnt1) begin
            r_scnt <= '0;
         end else if (r_scnt != '1) begin
            r_scnt <= r_scnt + 1'b1;
         end
      end
   end

   // ---------------- return tag pipeline ----------------
   // Shift in at bit 0; the entry leaving at bit READ_LAT-1 is the one whose
   // data is on ram_rdata this cycle. Built as a concatenation so that a
   // one-deep pipeline needs no special case.
   assign w_tag_v_nxt = {r_tag_v, w_gnt0 | w_gnt1};
   assign w_tag_p_nxt = {r_tag_p, w_gnt1};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_tag_v <= '0;
         r_tag_p <= '0;
      end else begin
         r_tag_v <= w_tag_v_nxt[READ_LAT-1:0];
         r_tag_p <= w_tag_p_nxt[READ_LAT-1:0];
      end
   end

   // Gating with rst_n keeps rvalid low during reset, so a read whose return
   // coincides with the reset cycle is dropped along with the rest.
   assign w_rv0 = rst_n & r_tag_v[READ_LAT-1] & ~r_tag_p[READ_LAT-1];
   assign w_rv1 = rst_n & r_tag_v[READ_LAT-1] &  r_tag_p[READ_LAT-1];

   assign rvalid0 = w_rv0;
   assign rvalid1 = w_rv1;

   // ram_rdata is only valid during the return cycle itself, so it is passed
   // straight through then and captured to hold the value afterwards.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rdata0 <= '0;
         r_rdata1 <= '0;
      end else begin
         if (w_rv0) r_rdata0 <= ram_rdata;
         if (w_rv1) r_rdata1 <= ram_rdata;
      end
   end

   assign rdata0 = w_rv0 ? ram_rdata : r_rdata0;
   assign rdata1 = w_rv1 ? ram_rdata : r_rdata1;

endmodule

// File: doc/ram_rd_arbiter.md
Name: ram_rd_arbiter

Overview:
Shares one read port of the picture RAM between two requesters: the display scanner (port 0, latency-critical) and the CNN feature fetch (port 1, throughput-tolerant). It grants one request per cycle, drives the RAM address and read strobe, and routes returned data back to the winner after a fixed RAM latency. A starvation guard bounds the wait on port 1, and a hold input blocks all reads while the Bluetooth writer fills the frame.

Parameters:
AW, 10, address width (784-pixel frame fits in 1024 words)
DW, 8, data width (grey pixel)
READ_LAT, 1, RAM read latency in cycles, from ram_rd to valid ram_rdata; legal range 1..4
STARVE_MAX, 8, number of consecutive denied cycles on port 1 before it is forced to win; 0 disables the guard

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous reset, active low
hold  in  1  1 = no grants issued (frame being written)
req0  in  1  port 0 read request (level; held until granted)
addr0  in  AW  port 0 read address
gnt0  out  1  port 0 request accepted this cycle
rvalid0  out  1  rdata0 valid
rdata0  out  DW  port 0 read data
req1  in  1  port 1 read request
addr1  in  AW  port 1 read address
gnt1  out  1  port 1 request accepted this cycle
rvalid1  out  1  rdata1 valid
rdata1  out  DW  port 1 read data
ram_rd  out  1  RAM read strobe
ram_addr  out  AW  RAM read address
ram_rdata  in  DW  RAM read data

Behaviour:
- Arbitration is combinational within the cycle: at most one of gnt0/gnt1 is high; ram_rd = gnt0|gnt1; ram_addr = addr of the winner, else addr0.
- Default priority: port 0 wins whenever req0=1.
- Starvation counter scnt (width ceil(log2(STARVE_MAX+1)), min 1 bit): +1 on each cycle with req1=1, gnt1=0, hold=0; cleared on gnt1 or when req1=0; frozen while hold=1.
- When STARVE_MAX>0, scnt==STARVE_MAX, and req1=1, port 1 wins even if req0=1; scnt clears that cycle. port 0 sees gnt0=0 and keeps req0 asserted.
- A requester samples gnt on the clock edge; a request with gnt=0 must be held unchanged (req and addr) by the requester.
- hold=1: gnt0=gnt1=ram_rd=0. In-flight reads still complete and return data.
- Return path: tag shift register of depth READ_LAT, each entry {valid, port}, loaded from the grant each cycle. When the entry reaches the end of the register, rvalidN pulses for one cycle exactly READ_LAT cycles after gntN. rdataN = ram_rdata in that cycle; otherwise rdataN holds its last value.
- Throughput: one grant per cycle, back-to-back, with no bubble between ports.
- Reset (rst_n=0 at a clock edge): tag register cleared, scnt=0, rdata0=rdata1=0, rvalid0=rvalid1=0. While rst_n=0: gnt0=gnt1=ram_rd=0 and ram_addr=addr0. Reads in flight at reset are discarded, and no rvalid is produced for them after reset releases.
- No state machine beyond scnt and the tag pipeline. Everything except the grant mux is registered.

Test Plan:
- READ_LAT=1, only req1 with addr1=0x005, RAM word 5=0xA7 -> gnt1 in the same cycle, ram_addr=0x005; the next cycle has rvalid1=1, rdata1=0xA7, and rvalid0 stays 0.
- req0 and req1 both high for 3 cycles, STARVE_MAX=8 -> gnt0 in all 3 cycles; gnt1 arrives in cycle 4 after req0 drops; scnt reads 3 before clearing.
- STARVE_MAX=4, req0 and req1 held high continuously -> grant pattern 0,0,0,0,1 repeating (gnt1 on every 5th cycle); the rvalid tags match the ports; STARVE_MAX=0 -> gnt1 never asserts.
- READ_LAT=3, alternating grants 0,1,0,1 on addresses 10,20,11,21 -> rvalid0/rvalid1 alternate starting 3 cycles after the first grant, each with the correct word.
- hold=1 for 5 cycles during contention, with one read in flight -> no grants and scnt frozen; the in-flight read still returns its rvalid; arbitration resumes in the cycle hold drops.
- READ_LAT=2, rst_n=0 asserted one cycle after gnt0 -> no rvalid0 ever appears for that read; all outputs are 0 during reset; the first request after release is granted normally.
